// File: rtl/sr_mode_sequencer.sv
// Command sequencer for an 8-bit universal shift register.
// Each accepted command runs one parallel load, a counted shift burst, then a done pulse.
module sr_mode_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_SHIFT = 8,
  localparam int unsigned CW       = $clog2(MAX_SHIFT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir_in,
  input  logic             fill_in,
  input  logic [CW-1:0]    cnt_in,
  output logic [WIDTH-1:0] p_in,
  output logic             s1,
  output logic             s0,
  output logic             shiftleft_input,
  output logic             shiftright_input,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_cap_q;
  logic [CW-1:0]    cnt_sat;
  logic             dir_q, fill_q;
  logic [WIDTH-1:0] p_in_q;
  logic             in_ready_q, in_ready_d;
  logic             s1_q, s1_d, s0_q, s0_d;
  logic             sl_q, sl_d, sr_q, sr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             handshake;

  assign handshake = (state_q == StIdle) && in_valid && in_ready_q;
  assign cnt_sat   = (cnt_in > CW'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : cnt_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = (cnt_cap_q == '0) ? StDone : StShift;
      end
      StShift: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == cnt_cap_q - CW'(1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with state_q.
  always_comb begin
    in_ready_d = 1'b0;
    s1_d       = 1'b0;
    s0_d       = 1'b0;
    sl_d       = 1'b0;
    sr_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      StIdle: in_ready_d = 1'b1;
      StLoad: begin
        s1_d   = 1'b1;
        s0_d   = 1'b1;
        busy_d = 1'b1;
      end
      StShift: begin
        busy_d = 1'b1;
        if (dir_q) begin
          s1_d = 1'b1;
          sl_d = fill_q;
        end else begin
          s0_d = 1'b1;
          sr_d = fill_q;
        end
      end
      StDone: done_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cnt_cap_q  <= '0;
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      p_in_q     <= '0;
      in_ready_q <= 1'b1;
      s1_q       <= 1'b0;
      s0_q       <= 1'b0;
      sl_q       <= 1'b0;
      sr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      s1_q       <= s1_d;
      s0_q       <= s0_d;
      sl_q       <= sl_d;
      sr_q       <= sr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      // p_in is loaded at capture so it is already valid during the LOAD cycle.
      if (handshake) begin
        p_in_q    <= data_in;
        dir_q     <= dir_in;
        fill_q    <= fill_in;
        cnt_cap_q <= cnt_sat;
      end
    end
  end

  assign in_ready         = in_ready_q;
  assign p_in             = p_in_q;
  assign s1               = s1_q;
  assign s0               = s0_q;
  assign shiftleft_input  = sl_q;
  assign shiftright_input = sr_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: doc/sr_mode_sequencer.md
Name: sr_mode_sequencer

Overview:
- Control stage directly upstream of the 8-bit universal shift register.
- Accepts a parallel word plus a shift command over a valid/ready handshake.
- Drives the register's parallel-load bus, mode selects (s1,s0) and serial fill inputs.
- Sequence per command: one load cycle, then a counted burst of left or right shifts, then hold; a one-cycle done pulse marks completion.

Parameters:
- WIDTH, 8, parallel word width; matches the shift register data width.
- MAX_SHIFT, 8, largest accepted shift count; the cnt_in field is $clog2(MAX_SHIFT+1) bits wide (4 at default).

Ports:
- clk  input  1  rising-edge clock shared with the shift register.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  sequencer can accept a command (IDLE only).
- data_in  input  WIDTH  word to load.
- dir_in  input  1  0 = shift right, 1 = shift left.
- fill_in  input  1  serial bit shifted in on every shift cycle.
- cnt_in  input  $clog2(MAX_SHIFT+1)  number of shift cycles, 0..MAX_SHIFT.
- p_in  output  WIDTH  parallel load value to the register.
- s1  output  1  mode select high bit.
- s0  output  1  mode select low bit.
- shiftleft_input  output  1  serial bit for left shifts.
- shiftright_input  output  1  serial bit for right shifts.
- busy  output  1  command in progress (LOAD or SHIFT).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Mode encoding {s1,s0}: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- All outputs are registered. Reset values: p_in=0, s1=s0=0, shiftleft_input=shiftright_input=0, busy=0, done=0; in_ready=1 after reset.
- Reset wins over every other event, including mid-LOAD or mid-SHIFT. The next cycle is IDLE with all outputs at their reset values. The aborted command is dropped and no done pulse is produced.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Outputs {s1,s0}=00, in_ready=1, busy=0.
  - A handshake occurs when in_valid and in_ready are both 1 at a clock edge.
  - On handshake, capture data_in, dir_in, fill_in and cnt_in; next state is LOAD.
- LOAD (exactly 1 cycle):
  - {s1,s0}=11, p_in=captured data, busy=1.
  - If captured cnt=0, next state is DONE; otherwise next state is SHIFT with the counter cleared.
- SHIFT (exactly cnt cycles):
  - {s1,s0}=01 if dir=0, or 10 if dir=1; busy=1.
  - The active-side serial output (shiftright_input for dir=0, shiftleft_input for dir=1) equals the captured fill bit.
  - The inactive-side serial output is 0.
  - The counter increments each cycle; on the cycle where counter = cnt-1, next state is DONE.
- DONE (1 cycle): {s1,s0}=00, done=1, busy=0, in_ready=0. Next state is IDLE.
- Output timing: each state's output values appear the cycle after the edge that entered the state. The register therefore samples them on the following edge.
- Throughput: a command occupies 1 + cnt + 1 cycles; the next handshake is possible on the first IDLE cycle.
- Outside LOAD, p_in holds the last captured value (0 after reset). It is don't-care to the register.
- cnt_in > MAX_SHIFT is saturated to MAX_SHIFT at capture.
- in_valid while not in IDLE is ignored: no capture, no back-pressure violation.
- data_in, dir_in, fill_in and cnt_in changing after capture have no effect on the current command.

Test Plan:
- Reset then idle: assert rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=1 after release, no capture during reset.
- Right shift: data_in=8'hFF, dir=0, fill=0, cnt=4 -> 1 cycle {s1,s0}=11 with p_in=FF, then 4 cycles 01 with shiftright_input=0, then done=1 for 1 cycle. Attached register ends at 8'h0F.
- Left shift: data_in=8'hAA, dir=1, fill=1, cnt=8 -> LOAD, then 8 cycles 10 with shiftleft_input=1 and shiftright_input=0, then done. Register reads 8'hFF.
- Zero count: data_in=8'hCC, cnt=0 -> LOAD, then DONE immediately; total 2 cycles busy/done. Register holds 8'hCC.
- Saturation and ignored input: cnt_in=15 -> exactly 8 shift cycles. Toggle in_valid and data_in during SHIFT -> no effect on outputs. A second command is accepted on the first IDLE cycle.
- Reset mid-SHIFT: rst asserted at shift cycle 3 of 8 -> next cycle {s1,s0}=00, busy=0, and no done pulse ever appears for that command.
